// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, address limit and state encodings for the audio SRAM path.
package audio_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        A_IDLE,
        A_WR1,
        A_WR2,
        A_RD1,
        A_RD2
    } acc_state_t;

endpackage

// File: rtl/sram_port_seq.sv
// sram_port_seq: two-cycle SRAM access sequencer. Owns the strobes, the address
// pins and the data-bus driver; the parent only says which kind of access is due.
module sram_port_seq #(
    parameter int AW = 18,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_go,
    input  logic          rd_go,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic          wr_busy,
    output logic          rd_busy,
    output logic          wr_done,
    output logic          rd_done,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] addr,
    inout  logic [DW-1:0] io,
    output logic          ce,
    output logic          oe,
    output logic          we
);
    import audio_pkg::*;

    acc_state_t    state;
    logic          io_oe;
    logic [DW-1:0] dout;

    assign wr_busy = (state == A_WR1) || (state == A_WR2);
    assign rd_busy = (state == A_RD1) || (state == A_RD2);

    // The bus is driven for the whole write (WR2 is the data-hold cycle) and released after.
    assign io = io_oe ? dout : 'z;

    // Access FSM; every pin is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= A_IDLE;
            addr    <= '0;
            dout    <= '0;
            io_oe   <= 1'b0;
            ce      <= 1'b1;
            oe      <= 1'b1;
            we      <= 1'b1;
            wr_done <= 1'b0;
            rd_done <= 1'b0;
            rd_data <= '0;
        end else begin
            wr_done <= 1'b0;
            rd_done <= 1'b0;
            case (state)
                A_IDLE: begin
                    if (wr_go) begin
                        state <= A_WR1;
                        addr  <= wr_addr;
                        dout  <= wr_data;
                        io_oe <= 1'b1;
                        ce    <= 1'b0;
                        we    <= 1'b0;
                    end else if (rd_go) begin
                        state <= A_RD1;
                        addr  <= rd_addr;
                        ce    <= 1'b0;
                        oe    <= 1'b0;
                    end
                end
                A_WR1: begin
                    state   <= A_WR2;
                    we      <= 1'b1;
                    wr_done <= 1'b1;
                end
                A_WR2: begin
                    state <= A_IDLE;
                    ce    <= 1'b1;
                    io_oe <= 1'b0;
                end
                A_RD1: begin
                    state   <= A_RD2;
                    rd_data <= io;
                    ce      <= 1'b1;
                    oe      <= 1'b1;
                    rd_done <= 1'b1;
                end
                A_RD2:   state <= A_IDLE;
                default: state <= A_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: RECORD/PLAY/IDLE mode machine and request arbiter in front of the
// audio SRAM. rec_len carries one extra bit so a completely full memory still
// reports its true sample count instead of wrapping to zero.
module sram_ctrl #(
    parameter int ADDR_W = audio_pkg::ADDR_W,
    parameter int DATA_W = audio_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_record,
    input  logic              cmd_play,
    input  logic              cmd_stop,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] addr_o,
    inout  logic [DATA_W-1:0] io,
    output logic              ce,
    output logic              oe,
    output logic              we,
    output logic              ub,
    output logic              lb,
    output logic [1:0]        mode_o,
    output logic [ADDR_W:0]   rec_len,
    output logic              full,
    output logic              ovf,
    output logic              play_done
);
    import audio_pkg::*;

    mode_t             mode;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] wr_data_q;
    logic              wr_pend, rd_pend;
    logic              wr_busy, rd_busy;
    logic              mode_chg;
    logic              wr_cap, rd_cap, wr_new, rd_new, wr_go, rd_go;
    logic              seq_idle;
    logic [ADDR_W:0]   rd_next;

    assign ub     = 1'b0;
    assign lb     = 1'b0;
    assign mode_o = mode;

    // Request capture: a request is dropped on a mode-change cycle and flagged as
    // overflow when the same kind is already pending or in service.
    always_comb begin
        mode_chg = cmd_stop | cmd_record | (cmd_play && (rec_len != '0));
        seq_idle = !wr_busy && !rd_busy;
        wr_cap   = wr_req && (mode == RECORD) && !mode_chg;
        rd_cap   = rd_req && (mode == PLAY) && !mode_chg;
        wr_new   = wr_cap && !wr_pend && !wr_busy;
        rd_new   = rd_cap && !rd_pend && !rd_busy;
        wr_go    = (wr_pend && !mode_chg) || wr_new;
        rd_go    = (rd_pend && !mode_chg) || rd_new;
        rd_next  = {1'b0, rd_ptr} + (ADDR_W+1)'(1);
    end

    // Mode machine, pointers and status; commands are applied last so they win
    // over a completing access on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode      <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rec_len   <= '0;
            full      <= 1'b0;
            ovf       <= 1'b0;
            play_done <= 1'b0;
            wr_pend   <= 1'b0;
            rd_pend   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            play_done <= 1'b0;

            if (wr_ack) begin
                rec_len <= {1'b0, wr_ptr} + (ADDR_W+1)'(1);
                if (wr_ptr == ADDR_W'(MAX_ADDR)) begin
                    full <= 1'b1;
                    mode <= IDLE;
                end else begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
            end

            if (rd_valid) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
                if (rd_next == rec_len) begin
                    mode      <= IDLE;
                    play_done <= 1'b1;
                end
            end

            if ((wr_cap && (wr_pend || wr_busy)) || (rd_cap && (rd_pend || rd_busy)))
                ovf <= 1'b1;

            if (cmd_stop) begin
                mode <= IDLE;
            end else if (cmd_record) begin
                wr_ptr  <= '0;
                rec_len <= '0;
                full    <= 1'b0;
                ovf     <= 1'b0;
                mode    <= RECORD;
            end else if (cmd_play && (rec_len != '0)) begin
                rd_ptr <= '0;
                mode   <= PLAY;
            end

            // A flag only lingers while the sequencer is still busy with the other kind.
            if (mode_chg)                  wr_pend <= 1'b0;
            else if (wr_go && seq_idle)    wr_pend <= 1'b0;
            else if (wr_new)               wr_pend <= 1'b1;

            if (mode_chg)                  rd_pend <= 1'b0;
            else if (rd_go && seq_idle && !wr_go) rd_pend <= 1'b0;
            else if (rd_new)               rd_pend <= 1'b1;

            if (wr_new) wr_data_q <= wr_data;
        end
    end

    sram_port_seq #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_seq (
        .clk     (clk),
        .reset   (reset),
        .wr_go   (wr_go),
        .rd_go   (rd_go),
        .wr_addr (wr_ptr),
        .wr_data (wr_pend ? wr_data_q : wr_data),
        .rd_addr (rd_ptr),
        .wr_busy (wr_busy),
        .rd_busy (rd_busy),
        .wr_done (wr_ack),
        .rd_done (rd_valid),
        .rd_data (rd_data),
        .addr    (addr_o),
        .io      (io),
        .ce      (ce),
        .oe      (oe),
        .we      (we)
    );

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed stimulus against a cycle-stamped behavioural model, plus
// a second small-address instance used to reach the end-of-memory boundary.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_record = 0, cmd_play = 0, cmd_stop = 0;
    logic        wr_req = 0, rd_req = 0;
    logic [15:0] wr_data = '0;
    logic        wr_ack, rd_valid, ce, oe, we, ub, lb, full, ovf, play_done;
    logic [15:0] rd_data;
    logic [17:0] addr_o;
    logic [1:0]  mode_o;
    logic [18:0] rec_len;
    wire  [15:0] io;

    // small instance (16-word memory)
    logic        s_cmd_record = 0, s_wr_req = 0;
    logic [15:0] s_wr_data = '0;
    logic        s_wr_ack, s_rd_valid, s_ce, s_oe, s_we, s_ub, s_lb, s_full, s_ovf, s_play_done;
    logic [15:0] s_rd_data;
    logic [3:0]  s_addr;
    logic [1:0]  s_mode;
    logic [4:0]  s_rec_len;
    wire  [15:0] s_io;

    always #5 clk = ~clk;

    sram_ctrl dut (
        .clk(clk), .reset(reset), .cmd_record(cmd_record), .cmd_play(cmd_play),
        .cmd_stop(cmd_stop), .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .addr_o(addr_o),
        .io(io), .ce(ce), .oe(oe), .we(we), .ub(ub), .lb(lb), .mode_o(mode_o),
        .rec_len(rec_len), .full(full), .ovf(ovf), .play_done(play_done)
    );

    sram_ctrl #(.ADDR_W(4), .DATA_W(16)) u_small (
        .clk(clk), .reset(reset), .cmd_record(s_cmd_record), .cmd_play(1'b0),
        .cmd_stop(1'b0), .wr_req(s_wr_req), .wr_data(s_wr_data), .wr_ack(s_wr_ack),
        .rd_req(1'b0), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .addr_o(s_addr),
        .io(s_io), .ce(s_ce), .oe(s_oe), .we(s_we), .ub(s_ub), .lb(s_lb), .mode_o(s_mode),
        .rec_len(s_rec_len), .full(s_full), .ovf(s_ovf), .play_done(s_play_done)
    );

    // external SRAM behaviour for the main instance
    logic [15:0] sram [0:1023];
    assign io = (!ce && !oe && we) ? sram[addr_o[9:0]] : 'z;
    always @(posedge clk) if (!ce && !we) sram[addr_o[9:0]] <= io;

    // write log for the small instance
    int s_wr_cnt [16];
    int s_ack_n = 0;
    always @(posedge clk) begin
        if (reset && !s_ce && !s_we) s_wr_cnt[s_addr] <= s_wr_cnt[s_addr] + 1;
        if (s_wr_ack) s_ack_n <= s_ack_n + 1;
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An access captured in cycle t0 occupies t0+1 (phase 1) and t0+2 (phase 2);
    // its bookkeeping lands on the edge that closes t0+2.
    localparam int MAXA = (1 << 18) - 1;
    int          cyc = 0;
    logic [1:0]  m_mode;
    int          m_rec_len, m_wr_ptr, m_rd_ptr, m_pd_cyc, m_addr;
    bit          m_full, m_ovf;
    bit          a_act, a_wr;
    int          a_t0, a_addr;
    logic [15:0] a_data, m_rd_data;
    logic [15:0] m_mem [0:1023];

    always @(posedge clk) begin : model
        int c, o_len;
        logic [1:0] o_mode;
        bit busy, chg;
        c = cyc;
        if (!reset) begin
            m_mode = 2'd0; m_rec_len = 0; m_wr_ptr = 0; m_rd_ptr = 0;
            m_full = 0; m_ovf = 0; a_act = 0; m_pd_cyc = -1; m_addr = 0; m_rd_data = '0;
        end else begin
            o_mode = m_mode; o_len = m_rec_len; busy = a_act;
            chg = cmd_stop || cmd_record || (cmd_play && o_len != 0);
            if (a_act && !a_wr && c == a_t0 + 1) m_rd_data = m_mem[a_addr % 1024];
            if (a_act && c == a_t0 + 2) begin
                a_act = 0;
                if (a_wr) begin
                    m_mem[a_addr % 1024] = a_data;
                    m_rec_len = a_addr + 1;
                    if (a_addr == MAXA) begin m_full = 1; m_mode = 2'd0; end
                    else m_wr_ptr = a_addr + 1;
                end else begin
                    m_rd_ptr = a_addr + 1;
                    if (a_addr + 1 == m_rec_len) begin m_mode = 2'd0; m_pd_cyc = c + 1; end
                end
            end
            if (cmd_stop) m_mode = 2'd0;
            else if (cmd_record) begin
                m_wr_ptr = 0; m_rec_len = 0; m_full = 0; m_ovf = 0; m_mode = 2'd1;
            end else if (cmd_play && o_len != 0) begin
                m_rd_ptr = 0; m_mode = 2'd2;
            end
            if (!chg && wr_req && o_mode == 2'd1) begin
                if (busy) m_ovf = 1;
                else begin a_act = 1; a_wr = 1; a_t0 = c; a_addr = m_wr_ptr; a_data = wr_data; m_addr = m_wr_ptr; end
            end
            if (!chg && rd_req && o_mode == 2'd2) begin
                if (busy) m_ovf = 1;
                else begin a_act = 1; a_wr = 0; a_t0 = c; a_addr = m_rd_ptr; m_addr = m_rd_ptr; end
            end
        end
        cyc = cyc + 1;
    end

    // per-cycle comparison of every main-instance output against the model
    always @(negedge clk) begin : cmp
        int ph;
        if (cyc > 0) begin
            ph = 0;
            if (a_act && cyc == a_t0 + 1) ph = 1;
            else if (a_act && cyc == a_t0 + 2) ph = 2;
            chk("ce", ce, !(ph == 1 || (ph == 2 && a_wr)));
            chk("we", we, !(ph == 1 && a_wr));
            chk("oe", oe, !(ph == 1 && !a_wr));
            chk("io_drive", dut.u_seq.io_oe, a_wr && ph != 0);
            if (a_wr && ph != 0) chk("io_data", io, a_data);
            chk("addr_o", addr_o, m_addr);
            chk("wr_ack", wr_ack, ph == 2 && a_wr);
            chk("rd_valid", rd_valid, ph == 2 && !a_wr);
            chk("rd_data", rd_data, m_rd_data);
            chk("mode", mode_o, m_mode);
            chk("rec_len", rec_len, m_rec_len);
            chk("full", full, m_full);
            chk("ovf", ovf, m_ovf);
            chk("play_done", play_done, cyc == m_pd_cyc);
            chk("ub_lb", {ub, lb}, 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_cmd(input bit s, input bit r, input bit p);
        @(negedge clk); cmd_stop = s; cmd_record = r; cmd_play = p;
        @(negedge clk); cmd_stop = 0; cmd_record = 0; cmd_play = 0;
    endtask

    task automatic drive_wr(input logic [15:0] d);
        @(negedge clk); wr_req = 1; wr_data = d;
        @(negedge clk); wr_req = 0;
    endtask

    task automatic drive_rd();
        @(negedge clk); rd_req = 1;
        @(negedge clk); rd_req = 0;
    endtask

    initial begin
        logic [15:0] samples [3];
        samples[0] = 16'h1111; samples[1] = 16'h2222; samples[2] = 16'h3333;

        idle(3);
        reset = 1;
        idle(2);
        chk("rst_ce_we_oe", {ce, we, oe}, 3'b111);
        chk("rst_mode", mode_o, 0);
        chk("rst_rec_len", rec_len, 0);

        // play with nothing recorded is ignored
        pulse_cmd(0, 0, 1);
        idle(1);
        chk("play_empty_mode", mode_o, 0);

        // record three samples
        pulse_cmd(0, 1, 0);
        idle(2);
        for (int i = 0; i < 3; i++) begin
            drive_wr(samples[i]);
            chk("wr_we_low", we, 0);
            chk("wr_addr", addr_o, i);
            @(negedge clk);
            chk("wr_ack_t2", wr_ack, 1);
            idle(7);
        end
        chk("lit_rec_len3", rec_len, 3);
        chk("lit_mode_rec", mode_o, 1);
        chk("lit_sram2", sram[2], 16'h3333);

        // play them back; the fourth request falls into IDLE
        pulse_cmd(0, 0, 1);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            drive_rd();
            @(negedge clk);
            if (i < 3) begin
                chk("lit_rd_valid", rd_valid, 1);
                chk("lit_rd_data", rd_data, samples[i]);
            end else begin
                chk("lit_rd4_ignored", rd_valid, 0);
            end
            if (i == 2) begin
                @(negedge clk);
                chk("lit_play_done", play_done, 1);
                chk("lit_mode_idle", mode_o, 0);
            end
            idle(4);
        end

        // back-to-back write requests
        pulse_cmd(0, 1, 0);
        idle(2);
        @(negedge clk); wr_req = 1; wr_data = 16'hAAAA;
        @(negedge clk); wr_data = 16'hBBBB;
        @(negedge clk); wr_req = 0;
        idle(5);
        chk("lit_ovf", ovf, 1);
        chk("lit_ovf_len", rec_len, 1);
        chk("lit_ovf_sram0", sram[0], 16'hAAAA);
        chk("lit_ovf_sram1", sram[1], 16'h2222);

        // stop beats record
        pulse_cmd(1, 1, 0);
        idle(2);
        chk("lit_stoprec_mode", mode_o, 0);
        chk("lit_stoprec_len", rec_len, 1);

        // reset while the second write is in WR1
        pulse_cmd(0, 1, 0);
        idle(2);
        drive_wr(16'h5555);
        idle(4);
        chk("lit_pre_rst_len", rec_len, 1);
        drive_wr(16'h6666);
        chk("lit_wr1_ce", ce, 0);
        reset = 0;
        @(negedge clk);
        chk("lit_rst_ce", ce, 1);
        chk("lit_rst_we", we, 1);
        chk("lit_rst_io", dut.u_seq.io_oe, 0);
        chk("lit_rst_mode", mode_o, 0);
        chk("lit_rst_len", rec_len, 0);
        reset = 1;
        idle(2);

        // small instance: fill all 16 words
        @(negedge clk); s_cmd_record = 1;
        @(negedge clk); s_cmd_record = 0;
        idle(1);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("lit_s_not_full", s_full, 0);
            @(negedge clk); s_wr_req = 1; s_wr_data = 16'(i + 256);
            @(negedge clk); s_wr_req = 0;
            idle(3);
        end
        chk("lit_s_full", s_full, 1);
        chk("lit_s_mode", s_mode, 0);
        chk("lit_s_len", s_rec_len, 5'h10);
        chk("lit_s_acks", s_ack_n, 16);
        @(negedge clk); s_wr_req = 1;
        @(negedge clk); s_wr_req = 0;
        idle(4);
        chk("lit_s_no_wrap", s_wr_cnt[0], 1);
        chk("lit_s_last", s_wr_cnt[15], 1);
        chk("lit_s_acks_after", s_ack_n, 16);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
